// File: rtl/ram_arbiter_np.sv
// N-port round-robin arbiter in front of one single-port RAM; grant is combinational, rvalid follows one cycle later.
// Define RAM_ARB_PORT0_PRIO_EN to give port 0 fixed priority over a round-robin among ports 1..N-1.
module ram_arbiter_np #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_req_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr_i,
  input  logic [NUM_PORTS-1:0]             port_we_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    port_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata_i,
  output logic [NUM_PORTS-1:0]             port_gnt_o,
  output logic [NUM_PORTS-1:0]             port_rvalid_o,
  output logic [DATA_WIDTH-1:0]            port_rdata_o,
  output logic                             ram_en_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic                             ram_we_o,
  output logic [BE_WIDTH-1:0]              ram_be_o,
  output logic [DATA_WIDTH-1:0]            ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

`ifdef RAM_ARB_PORT0_PRIO_EN
  localparam logic [ID_WIDTH-1:0] PTR_MIN = ID_WIDTH'(1);
`else
  localparam logic [ID_WIDTH-1:0] PTR_MIN = '0;
`endif
  localparam logic [ID_WIDTH-1:0] PTR_MAX = ID_WIDTH'(NUM_PORTS - 1);

  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [NUM_PORTS-1:0]  r_rvalid;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [ID_WIDTH-1:0]   w_rr_ptr_next;
  logic [NUM_PORTS-1:0]  w_gnt;

  logic [ADDR_WIDTH-1:0] w_addr_m  [NUM_PORTS];
  logic [BE_WIDTH-1:0]   w_be_m    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata_m [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_we_m;

  // Walk ports starting at r_rr_ptr; the wrap is explicit so non-power-of-2 counts stay in range.
  always_comb begin : winner_search
    int                  idx;
    logic [ID_WIDTH-1:0] sel;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    sel      = '0;
`ifdef RAM_ARB_PORT0_PRIO_EN
    if (port_req_i[0]) begin
      w_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS - 1; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx > NUM_PORTS - 1) idx = idx - (NUM_PORTS - 1);
        sel = ID_WIDTH'(idx);
        if (!w_found && port_req_i[sel]) begin
          w_found  = 1'b1;
          w_winner = sel;
        end
      end
    end
`else
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      sel = ID_WIDTH'(idx);
      if (!w_found && port_req_i[sel]) begin
        w_found  = 1'b1;
        w_winner = sel;
      end
    end
`endif
  end

  always_comb begin : ptr_update
    w_rr_ptr_next = r_rr_ptr;
`ifdef RAM_ARB_PORT0_PRIO_EN
    if (w_found && (w_winner != '0)) begin
`else
    if (w_found) begin
`endif
      w_rr_ptr_next = (w_winner == PTR_MAX) ? PTR_MIN : w_winner + 1'b1;
    end
  end

  always_comb begin : grant_decode
    w_gnt = '0;
    if (w_found && !rst) w_gnt[w_winner] = 1'b1;
  end

  // Each port's fields are gated by its own grant, so the OR below is zero when nobody wins.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_addr_m[gi]  = w_gnt[gi] ? port_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      assign w_be_m[gi]    = w_gnt[gi] ? port_be_i[gi*BE_WIDTH +: BE_WIDTH] : '0;
      assign w_wdata_m[gi] = w_gnt[gi] ? port_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign w_we_m[gi]    = w_gnt[gi] & port_we_i[gi];
    end
  endgenerate

  always_comb begin : field_mux
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ram_addr_o  = ram_addr_o  | w_addr_m[i];
      ram_be_o    = ram_be_o    | w_be_m[i];
      ram_wdata_o = ram_wdata_o | w_wdata_m[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= PTR_MIN;
      r_rvalid <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_next;
      r_rvalid <= w_gnt;
    end
  end

  assign port_gnt_o    = w_gnt;
  assign port_rvalid_o = r_rvalid;
  assign port_rdata_o  = ram_rdata_i;
  assign ram_en_o      = (|port_req_i) & ~rst;
  assign ram_we_o      = |w_we_m;

endmodule
